conv_stream_receiver: RTL and testbench
=======================================

CONV_STREAM_RECEIVER -- requirements
Module: conv_stream_receiver

Interface
REQ-001 Parameters: DW, default 8, signed lane width; FMAP_W, default 64, feature-map width and height; KSZ, default 4, kernel edge.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 in_start_conv  input  1  level; high starts and sustains a convolution stream.
REQ-005 in_cfg_ci  input  3  channel count code: 0..3 gives 8/16/24/32; values above 3 give 32.
REQ-006 in_cfg_co  input  3  kernel count code, same encoding as in_cfg_ci.
REQ-007 in_data0..in_data7  input  8 x DW  one beat per cycle.
REQ-008 o_kernel  output  16*DW  weights; value i at bits [DW*i +: DW].
REQ-009 o_kernel_valid  output  1  one-cycle pulse when o_kernel is updated.
REQ-010 o_win0, o_win1  output  16*DW each  4x4 windows; element (r,c) at bits [DW*(4r+c) +: DW].
REQ-011 o_win0_valid, o_win1_valid  output  1 each  window qualifiers.
REQ-012 o_knl_id  output 5, o_chnl_id  output 5, o_row  output 6, o_col0  output 6  tags for o_win0; o_win1 starts at column o_col0+1.
REQ-013 o_last_chnl  output  1  high with window valids when o_chnl_id is the last channel.
REQ-014 o_done  output  1  one-cycle pulse after the final beat of the final kernel.

Function
REQ-015 The FSM SHALL have states IDLE, KLOAD, DATA, and DONE; IDLE moves to KLOAD on the first edge that samples in_start_conv=1; in_cfg_ci and in_cfg_co are latched on that edge.
REQ-016 KLOAD SHALL sample 2 beats: beat 0 lanes 0..7 go to weights 0..7, and beat 1 lanes 0..7 go to weights 8..15; o_kernel_valid pulses on the cycle after beat 1 is sampled, and o_kernel then holds until the next KLOAD completes.
REQ-017 DATA SHALL sample 32 beats per row for 61 rows (0..60), which is 1952 beats per channel; beat k of a row carries column 2k in lanes 0..3 (rows r..r+3) and column 2k+1 in lanes 4..7.
REQ-018 The receiver SHALL keep a 4-row x 5-column shift buffer; the buffer content from the previous row SHALL NOT contribute to a new row.
REQ-019 On row beat k=0, no window SHALL be valid; on k=1, only win0 SHALL be valid, at column 0; on k=2..31, both windows SHALL be valid, with o_col0 = 2k-3; each row SHALL produce 61 windows.
REQ-020 Window outputs SHALL be registered: latency 1 cycle from sampling the completing beat; the valids are single-cycle per beat.
REQ-021 After the last beat of a channel, the FSM SHALL enter KLOAD for the next channel with no idle cycle, and o_chnl_id SHALL increment.
REQ-022 After channel NCH-1, o_chnl_id SHALL wrap to 0 and o_knl_id SHALL increment; after kernel NKN-1, the FSM SHALL go to DONE and pulse o_done 1 cycle after the final beat, coincident with the final window valids.
REQ-023 DONE SHALL ignore data and return to IDLE when in_start_conv is sampled 0.
REQ-024 If in_start_conv is sampled 0 in KLOAD or DATA, the stream SHALL abort: the FSM goes to IDLE, counters clear, window valids go low next cycle, and o_done is not asserted.
REQ-025 Data SHALL pass through unaltered, signed DW bits, with no arithmetic.

Reset
REQ-026 While rst_n=0, the FSM SHALL be IDLE, all counters 0, and every output 0, including o_kernel and the window buses.
REQ-027 Reset asserted mid-stream SHALL take effect immediately; after release, a new stream SHALL require a fresh in_start_conv sample.

Verification
REQ-028 Kernel load: start=1; beat0 lanes=1..8; beat1 lanes=9..16 -> o_kernel_valid pulses 1 cycle later with weights 0..15 = 1..16.
REQ-029 Row 0 with fmap(r,c)=c: beat1 -> only win0 valid, col0=0, every row of the window = {0,1,2,3}; beat2 -> col0=1, win0 row={1,2,3,4}, win1 row={2,3,4,5}.
REQ-030 Row wrap: last beat of row 0 (k=31) -> o_col0=59, win1 ends at column 63; next beat (row 1, k=0) -> no valid, o_row=1.
REQ-031 Full run with cfg_ci=0, cfg_co=0 -> 64 kernel_valid pulses, 8*8*61*61 = 238144 windows, o_done a single pulse, o_knl_id=7 at the end.
REQ-032 Channel wrap: cfg_ci=1 -> o_chnl_id counts 0..15 then 0 while o_knl_id increments; o_last_chnl is high only for channel 15.
REQ-033 Abort/reset: drop start mid-row -> no valids from the next cycle and o_done stays 0; pulse rst_n low in DATA -> all outputs 0 asynchronously, and a restart reloads the kernel.

Source files
------------

// File: rtl/conv_stream_receiver.sv
// Receives a kernel-then-feature-map beat stream and re-forms it into tagged
// 4x4 sliding windows, two per beat, for each channel of each kernel.
module conv_stream_receiver #(
  parameter int DW     = 8,
  parameter int FMAP_W = 64,
  parameter int KSZ    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_start_conv,
  input  logic [2:0]        in_cfg_ci,
  input  logic [2:0]        in_cfg_co,
  input  logic [DW-1:0]     in_data0,
  input  logic [DW-1:0]     in_data1,
  input  logic [DW-1:0]     in_data2,
  input  logic [DW-1:0]     in_data3,
  input  logic [DW-1:0]     in_data4,
  input  logic [DW-1:0]     in_data5,
  input  logic [DW-1:0]     in_data6,
  input  logic [DW-1:0]     in_data7,
  output logic [16*DW-1:0]  o_kernel,
  output logic              o_kernel_valid,
  output logic [16*DW-1:0]  o_win0,
  output logic [16*DW-1:0]  o_win1,
  output logic              o_win0_valid,
  output logic              o_win1_valid,
  output logic [4:0]        o_knl_id,
  output logic [4:0]        o_chnl_id,
  output logic [5:0]        o_row,
  output logic [5:0]        o_col0,
  output logic              o_last_chnl,
  output logic              o_done,
  output logic [1:0]        dbg_state
);

  localparam int BEATS = FMAP_W / 2;
  localparam int ROWS  = FMAP_W - KSZ + 1;
  localparam int BW    = $clog2(BEATS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_KLOAD = 2'd1,
    S_DATA  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              state;
  logic [4:0]          nch_m1;
  logic [4:0]          nkn_m1;
  logic [4:0]          chnl;
  logic [4:0]          knl;
  logic [5:0]          row;
  logic [BW-1:0]       beat;
  logic                kbeat;
  logic [8*DW-1:0]     kstage;
  logic [4*DW-1:0]     col_a;
  logic [4*DW-1:0]     col_b;
  logic [4*DW-1:0]     col_c;

  logic [8*DW-1:0]     cur;
  logic [4*DW-1:0]     cur_even;
  logic [4*DW-1:0]     cur_odd;

  // The stream has no backpressure: every cycle in KLOAD/DATA with
  // in_start_conv high consumes exactly one beat.
  assign cur      = {in_data7, in_data6, in_data5, in_data4,
                     in_data3, in_data2, in_data1, in_data0};
  assign cur_even = cur[4*DW-1:0];
  assign cur_odd  = cur[8*DW-1:4*DW];
  assign dbg_state = state;

  function automatic logic [4:0] last_idx(input logic [2:0] code);
    return (code > 3'd3) ? 5'd31 : {code[1:0], 3'b111};
  endfunction

  function automatic logic [16*DW-1:0] make_win(input logic [4*DW-1:0] c0,
                                               input logic [4*DW-1:0] c1,
                                               input logic [4*DW-1:0] c2,
                                               input logic [4*DW-1:0] c3);
    logic [16*DW-1:0] w;
    for (int r = 0; r < 4; r++) begin
      w[DW*(4*r+0) +: DW] = c0[DW*r +: DW];
      w[DW*(4*r+1) +: DW] = c1[DW*r +: DW];
      w[DW*(4*r+2) +: DW] = c2[DW*r +: DW];
      w[DW*(4*r+3) +: DW] = c3[DW*r +: DW];
    end
    return w;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      nch_m1         <= '0;
      nkn_m1         <= '0;
      chnl           <= '0;
      knl            <= '0;
      row            <= '0;
      beat           <= '0;
      kbeat          <= 1'b0;
      kstage         <= '0;
      col_a          <= '0;
      col_b          <= '0;
      col_c          <= '0;
      o_kernel       <= '0;
      o_kernel_valid <= 1'b0;
      o_win0         <= '0;
      o_win1         <= '0;
      o_win0_valid   <= 1'b0;
      o_win1_valid   <= 1'b0;
      o_knl_id       <= '0;
      o_chnl_id      <= '0;
      o_row          <= '0;
      o_col0         <= '0;
      o_last_chnl    <= 1'b0;
      o_done         <= 1'b0;
    end else begin
      o_kernel_valid <= 1'b0;
      o_win0_valid   <= 1'b0;
      o_win1_valid   <= 1'b0;
      o_last_chnl    <= 1'b0;
      o_done         <= 1'b0;

      if ((state == S_KLOAD || state == S_DATA) && !in_start_conv) begin
        // Abort: drop the stream, keep the last kernel on o_kernel.
        state     <= S_IDLE;
        chnl      <= '0;
        knl       <= '0;
        row       <= '0;
        beat      <= '0;
        kbeat     <= 1'b0;
        o_knl_id  <= '0;
        o_chnl_id <= '0;
        o_row     <= '0;
        o_col0    <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (in_start_conv) begin
              state  <= S_KLOAD;
              nch_m1 <= last_idx(in_cfg_ci);
              nkn_m1 <= last_idx(in_cfg_co);
              chnl   <= '0;
              knl    <= '0;
              row    <= '0;
              beat   <= '0;
              kbeat  <= 1'b0;
            end
          end

          S_KLOAD: begin
            o_knl_id  <= knl;
            o_chnl_id <= chnl;
            if (!kbeat) begin
              kstage <= cur;
              kbeat  <= 1'b1;
            end else begin
              o_kernel       <= {cur, kstage};
              o_kernel_valid <= 1'b1;
              kbeat          <= 1'b0;
              row            <= '0;
              beat           <= '0;
              state          <= S_DATA;
            end
          end

          S_DATA: begin
            // col_a..col_c hold the three newest columns of the current row.
            col_a     <= col_c;
            col_b     <= cur_even;
            col_c     <= cur_odd;
            o_knl_id  <= knl;
            o_chnl_id <= chnl;
            o_row     <= row;

            if (beat == '0) begin
              o_col0 <= '0;
            end else if (beat == BW'(1)) begin
              o_col0       <= '0;
              o_win0       <= make_win(col_b, col_c, cur_even, cur_odd);
              o_win0_valid <= 1'b1;
              o_last_chnl  <= (chnl == nch_m1);
            end else begin
              o_col0       <= 6'({beat, 1'b0}) - 6'd3;
              o_win0       <= make_win(col_a, col_b, col_c, cur_even);
              o_win1       <= make_win(col_b, col_c, cur_even, cur_odd);
              o_win0_valid <= 1'b1;
              o_win1_valid <= 1'b1;
              o_last_chnl  <= (chnl == nch_m1);
            end

            if (beat == BW'(BEATS - 1)) begin
              beat <= '0;
              if (row == 6'(ROWS - 1)) begin
                row <= '0;
                if (chnl == nch_m1) begin
                  if (knl == nkn_m1) begin
                    state  <= S_DONE;
                    o_done <= 1'b1;
                  end else begin
                    chnl  <= '0;
                    knl   <= knl + 5'd1;
                    state <= S_KLOAD;
                  end
                end else begin
                  chnl  <= chnl + 5'd1;
                  state <= S_KLOAD;
                end
              end else begin
                row <= row + 6'd1;
              end
            end else begin
              beat <= beat + BW'(1);
            end
          end

          S_DONE: begin
            if (!in_start_conv) begin
              state     <= S_IDLE;
              chnl      <= '0;
              knl       <= '0;
              row       <= '0;
              beat      <= '0;
              o_knl_id  <= '0;
              o_chnl_id <= '0;
              o_row     <= '0;
              o_col0    <= '0;
            end
          end

          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_conv_stream_receiver.sv
// Bench for conv_stream_receiver: random kernels and feature maps, windows
// predicted from fmap geometry and checked by a decoupled monitor.
module tb_conv_stream_receiver;

  localparam int DW     = 8;
  localparam int FMAP_W = 16;
  localparam int KSZ    = 4;
  localparam int BEATS  = FMAP_W / 2;
  localparam int ROWS   = FMAP_W - KSZ + 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_start_conv = 1'b0;
  logic [2:0]        in_cfg_ci = '0;
  logic [2:0]        in_cfg_co = '0;
  logic [DW-1:0]     in_data0 = '0, in_data1 = '0, in_data2 = '0, in_data3 = '0;
  logic [DW-1:0]     in_data4 = '0, in_data5 = '0, in_data6 = '0, in_data7 = '0;
  logic [16*DW-1:0]  o_kernel, o_win0, o_win1;
  logic              o_kernel_valid, o_win0_valid, o_win1_valid;
  logic [4:0]        o_knl_id, o_chnl_id;
  logic [5:0]        o_row, o_col0;
  logic              o_last_chnl, o_done;
  logic [1:0]        dbg_state;

  conv_stream_receiver #(.DW(DW), .FMAP_W(FMAP_W), .KSZ(KSZ)) dut (
    .clk(clk), .rst_n(rst_n), .in_start_conv(in_start_conv),
    .in_cfg_ci(in_cfg_ci), .in_cfg_co(in_cfg_co),
    .in_data0(in_data0), .in_data1(in_data1), .in_data2(in_data2), .in_data3(in_data3),
    .in_data4(in_data4), .in_data5(in_data5), .in_data6(in_data6), .in_data7(in_data7),
    .o_kernel(o_kernel), .o_kernel_valid(o_kernel_valid),
    .o_win0(o_win0), .o_win1(o_win1),
    .o_win0_valid(o_win0_valid), .o_win1_valid(o_win1_valid),
    .o_knl_id(o_knl_id), .o_chnl_id(o_chnl_id), .o_row(o_row), .o_col0(o_col0),
    .o_last_chnl(o_last_chnl), .o_done(o_done), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, expected stimulus to complete");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  typedef struct packed {
    logic [4:0]       knl;
    logic [4:0]       chnl;
    logic [5:0]       row;
    logic [5:0]       col;
    logic             last;
    logic [16*DW-1:0] win;
  } exp_t;

  exp_t              exp_q[$];
  logic [16*DW-1:0]  kern_q[$];
  logic [DW-1:0]     img [FMAP_W][FMAP_W];
  int                vectors = 0;
  int                errors = 0;
  int                done_seen = 0;
  int                done_exp = 0;
  logic [4:0]        end_knl = '0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
    vectors++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic logic [16*DW-1:0] ref_win(input int r, input int c);
    logic [16*DW-1:0] w;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        w[DW*(4*i+j) +: DW] = img[r+i][c+j];
    return w;
  endfunction

  // ---------------- monitor ----------------
  task automatic mon_win(input logic [16*DW-1:0] w, input logic [5:0] col, input string nm);
    exp_t e;
    if (exp_q.size() == 0) begin
      vectors++;
      errors++;
      $display("FAIL %s unexpected: valid at row %0d col %0d, expected no window", nm, o_row, col);
    end else begin
      e = exp_q.pop_front();
      check({nm, " data"}, 256'(w), 256'(e.win));
      check({nm, " tags knl/chnl/row/col/last"},
            256'({o_knl_id, o_chnl_id, o_row, col, o_last_chnl}),
            256'({e.knl, e.chnl, e.row, e.col, e.last}));
    end
  endtask

  always @(posedge clk) begin
    logic [16*DW-1:0] kexp;
    #1;
    if (o_kernel_valid) begin
      if (kern_q.size() == 0) begin
        vectors++;
        errors++;
        $display("FAIL kernel unexpected: got %0h, expected no kernel", o_kernel);
      end else begin
        kexp = kern_q.pop_front();
        check("kernel", 256'(o_kernel), 256'(kexp));
      end
    end
    if (o_win0_valid) mon_win(o_win0, o_col0, "win0");
    if (o_win1_valid) mon_win(o_win1, o_col0 + 6'd1, "win1");
    if (o_done) begin
      done_seen++;
      check("done with final windows",
            256'({o_win0_valid, o_win1_valid, exp_q.size() == 0, o_knl_id}),
            256'({1'b1, 1'b1, 1'b1, end_knl}));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_lanes(input logic [8*DW-1:0] v);
    in_data0 = v[0*DW +: DW];
    in_data1 = v[1*DW +: DW];
    in_data2 = v[2*DW +: DW];
    in_data3 = v[3*DW +: DW];
    in_data4 = v[4*DW +: DW];
    in_data5 = v[5*DW +: DW];
    in_data6 = v[6*DW +: DW];
    in_data7 = v[7*DW +: DW];
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " kernel"}, 256'(o_kernel), 256'(0));
    check({tag, " win0"}, 256'(o_win0), 256'(0));
    check({tag, " win1"}, 256'(o_win1), 256'(0));
    check({tag, " flags/tags/state"},
          256'({o_kernel_valid, o_win0_valid, o_win1_valid, o_knl_id, o_chnl_id,
                o_row, o_col0, o_last_chnl, o_done, dbg_state}), 256'(0));
  endtask

  // stop_kind: 0 run to completion, 1 drop start mid-row, 2 reset mid-row
  task automatic run_stream(input int ci, input int co, input int stop_at,
                            input int stop_kind, input bit directed);
    int nch;
    int nkn;
    int chan_idx;
    logic [16*DW-1:0] kw;
    logic [8*DW-1:0]  v;
    exp_t e;
    nch = (ci > 3) ? 32 : 8 * (ci + 1);
    nkn = (co > 3) ? 32 : 8 * (co + 1);
    chan_idx = 0;
    end_knl = 5'(nkn - 1);
    @(negedge clk);
    in_start_conv = 1'b1;
    in_cfg_ci = 3'(ci);
    in_cfg_co = 3'(co);
    for (int kn = 0; kn < nkn; kn++) begin
      for (int ch = 0; ch < nch; ch++) begin
        for (int i = 0; i < 16; i++)
          kw[DW*i +: DW] = (directed && chan_idx == 0) ? DW'(i + 1) : DW'($urandom);
        @(negedge clk);
        set_lanes(kw[8*DW-1:0]);
        @(negedge clk);
        set_lanes(kw[16*DW-1:8*DW]);
        kern_q.push_back(kw);
        for (int r = 0; r < FMAP_W; r++)
          for (int c = 0; c < FMAP_W; c++)
            img[r][c] = (directed && chan_idx == 0) ? DW'(c) : DW'($urandom);
        for (int r = 0; r < ROWS; r++) begin
          for (int k = 0; k < BEATS; k++) begin
            @(negedge clk);
            if (chan_idx == stop_at && r == 2 && k == 3) begin
              check("queue drained before stop", 256'(exp_q.size()), 256'(0));
              if (stop_kind == 1) begin
                in_start_conv = 1'b0;
                @(posedge clk);
                #1;
                check("abort outputs", 256'({o_win0_valid, o_win1_valid, o_done, dbg_state}), 256'(0));
                repeat (3) begin
                  @(negedge clk);
                  set_lanes(64'($urandom));
                  check("abort stays idle", 256'({o_win0_valid, o_win1_valid, o_done, dbg_state}), 256'(0));
                end
              end else begin
                rst_n = 1'b0;
                in_start_conv = 1'b0;
                #1;
                check_reset_outputs("mid-stream reset");
                repeat (2) @(negedge clk);
                rst_n = 1'b1;
                @(negedge clk);
                check("idle after reset release", 256'(dbg_state), 256'(0));
              end
              kern_q.delete();
              exp_q.delete();
              return;
            end
            for (int i = 0; i < 4; i++) begin
              v[DW*i +: DW]     = img[r+i][2*k];
              v[DW*(4+i) +: DW] = img[r+i][2*k+1];
            end
            set_lanes(v);
            // A window becomes available once its rightmost column arrives.
            for (int c0 = 2*k - 3; c0 <= 2*k - 2; c0++) begin
              if (c0 >= 0) begin
                e.knl  = 5'(kn);
                e.chnl = 5'(ch);
                e.row  = 6'(r);
                e.col  = 6'(c0);
                e.last = (ch == nch - 1);
                e.win  = ref_win(r, c0);
                exp_q.push_back(e);
              end
            end
            if (directed && chan_idx == 0 && r == 1 && k == 0) begin
              @(posedge clk);
              #1;
              check("row wrap no valid, row 1",
                    256'({o_win0_valid, o_win1_valid, o_row}), 256'({2'b00, 6'd1}));
            end
          end
        end
        chan_idx++;
      end
    end
    done_exp++;
    repeat (3) begin
      @(negedge clk);
      set_lanes(64'({$urandom, $urandom}));
    end
    check("done holds while start high", 256'(dbg_state), 256'(3));
    in_start_conv = 1'b0;
    @(negedge clk);
    check("idle after done", 256'(dbg_state), 256'(0));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    set_lanes('0);
    repeat (3) @(negedge clk);
    check_reset_outputs("initial reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle without start", 256'(dbg_state), 256'(0));

    run_stream(0, 0, -1, 0, 1'b1);
    run_stream(1, 0, -1, 0, 1'b0);
    run_stream(5, 0, 3, 1, 1'b0);
    run_stream(2, 1, 2, 2, 1'b0);
    run_stream(0, 0, -1, 0, 1'b0);

    repeat (3) @(negedge clk);
    check("pending windows", 256'(exp_q.size()), 256'(0));
    check("pending kernels", 256'(kern_q.size()), 256'(0));
    check("done pulse count", 256'(done_seen), 256'(done_exp));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
